// File: rtl/ags_pkg.sv
// Shared types and helpers for the multi-channel visible-to-hidden accumulate-and-sample core.
package ags_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_STOCH     = 2'd0,
    MODE_DET       = 2'd1,
    MODE_PROB      = 2'd2,
    MODE_STOCH_ALT = 2'd3
  } mode_t;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int unsigned ch);
    return (base ^ 16'(ch * 32'h0000_1F35)) | 16'h0001;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Wide helpers: callers truncate the result to their own width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] clamp_unsigned(input logic signed [63:0] v,
                                                        input int unsigned w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< w) - 64'sd1;
    if (v > hi) return hi;
    if (v < 64'sd0) return 64'sd0;
    return v;
  endfunction

endpackage

// File: rtl/ags_sampler.sv
// One hidden-unit channel: piecewise-linear sigmoid, private LFSR and compare,
// with state and probability registered on the SAMPLE cycle.
module ags_sampler
  import ags_pkg::*;
#(
  parameter int          BW_TS   = 24,
  parameter int          BW_PROB = 8,
  parameter int          FRAC    = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_en,
  input  mode_t                     mode,
  input  logic signed [BW_TS-1:0]   sum,
  output logic                      state,
  output logic [BW_PROB-1:0]        prob
);

  localparam int SHIFT = FRAC - BW_PROB + 2;
  localparam logic signed [63:0] MID = 64'sd1 <<< (BW_PROB - 1);

  logic [15:0]        lfsr_q;
  logic [BW_PROB-1:0] prob_d;
  logic               state_d;

  always_comb begin
    prob_d  = BW_PROB'(clamp_unsigned(64'(sum >>> SHIFT) + MID, BW_PROB));
    state_d = 1'b0;
    case (mode)
      MODE_DET:  state_d = ~sum[BW_TS-1];
      MODE_PROB: state_d = 1'b0;
      default:   state_d = prob_d > lfsr_q[BW_PROB-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      state  <= 1'b0;
      prob   <= '0;
    end else if (sample_en) begin
      lfsr_q <= lfsr_step(lfsr_q);
      state  <= state_d;
      prob   <= prob_d;
    end
  end

endmodule

// File: rtl/ags_array_vh.sv
// Multi-channel accumulate-and-sample core: per-channel saturating sums over a
// configurable number of beats, then one sigmoid/sample step per frame.
//   state  | meaning
//   IDLE   | waiting for the first beat of a frame (loads bias + data)
//   ACC    | accumulating the remaining beats
//   SAMPLE | one cycle: samplers register results, incoming beats dropped
module ags_array_vh
  import ags_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          BW_PS   = 16,
  parameter int          BW_TS   = 24,
  parameter int          BW_PROB = 8,
  parameter int          FRAC    = 8,
  parameter int          MAX_ACC = 32,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         CNT_W   = $clog2(MAX_ACC + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [CNT_W-1:0]            cfg_num_acc,
  input  logic [1:0]                  cfg_mode,
  input  logic [NUM_CH*BW_TS-1:0]     bias_in,
  input  logic                        data_in_en,
  input  logic [NUM_CH*BW_PS-1:0]     data_in,
  output logic [NUM_CH-1:0]           new_state,
  output logic [NUM_CH*BW_PROB-1:0]   new_prob,
  output logic                        new_state_en,
  output logic                        busy,
  output logic                        ovf_flag,
  output logic                        drop_err
);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        num_acc_q;
  logic [CNT_W-1:0]        num_acc_eff;
  mode_t                   mode_q;
  logic signed [BW_TS-1:0] sum_q  [NUM_CH];
  logic signed [BW_TS-1:0] sum_nx [NUM_CH];
  logic [NUM_CH-1:0]       hit;
  logic                    pulse_q, ovf_q, drop_q;
  logic                    accept, sample_en;

  assign accept    = en & data_in_en & (state_q != SAMPLE);
  assign sample_en = en & (state_q == SAMPLE);

  always_comb begin
    num_acc_eff = cfg_num_acc;
    if (cfg_num_acc == '0)
      num_acc_eff = CNT_W'(1);
    else if (cfg_num_acc > CNT_W'(MAX_ACC))
      num_acc_eff = CNT_W'(MAX_ACC);
  end

  // First beat adds onto the bias; later beats onto the running sum.
  always_comb begin
    logic signed [BW_TS-1:0] base;
    logic signed [BW_PS-1:0] dv;
    logic signed [BW_TS:0]   raw;
    base = '0;
    dv   = '0;
    raw  = '0;
    hit  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_nx[c] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      base      = (state_q == IDLE) ? bias_in[c*BW_TS +: BW_TS] : sum_q[c];
      dv        = data_in[c*BW_PS +: BW_PS];
      raw       = {base[BW_TS-1], base} + {{(BW_TS+1-BW_PS){dv[BW_PS-1]}}, dv};
      sum_nx[c] = BW_TS'(sat_signed(64'(raw), BW_TS));
      hit[c]    = ({sum_nx[c][BW_TS-1], sum_nx[c]} != raw);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (num_acc_eff == CNT_W'(1)) ? SAMPLE : ACC;
      ACC:     if (accept && (cnt_q + CNT_W'(1)) == num_acc_q) state_d = SAMPLE;
      SAMPLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      num_acc_q <= '0;
      mode_q    <= MODE_STOCH;
      for (int c = 0; c < NUM_CH; c++) sum_q[c] <= '0;
      pulse_q   <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      pulse_q <= (state_q == SAMPLE);
      if (data_in_en && state_q == SAMPLE) drop_q <= 1'b1;
      if (accept) begin
        for (int c = 0; c < NUM_CH; c++) sum_q[c] <= sum_nx[c];
        if (|hit) ovf_q <= 1'b1;
        if (state_q == IDLE) begin
          cnt_q     <= CNT_W'(1);
          num_acc_q <= num_acc_eff;
          mode_q    <= mode_t'(cfg_mode);
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end else begin
      pulse_q <= 1'b0;
    end
  end

  assign new_state_en = pulse_q;
  assign busy         = (state_q == SAMPLE);
  assign ovf_flag     = ovf_q;
  assign drop_err     = drop_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_smp
    ags_sampler #(
      .BW_TS  (BW_TS),
      .BW_PROB(BW_PROB),
      .FRAC   (FRAC),
      .SEED   (lfsr_seed(SEED, c))
    ) u_smp (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .mode     (mode_q),
      .sum      (sum_q[c]),
      .state    (new_state[c]),
      .prob     (new_prob[c*BW_PROB +: BW_PROB])
    );
  end

endmodule

// File: tb/tb_ags_array_vh.sv
// Self-checking bench for ags_array_vh against an arithmetic frame model.
module tb_ags_array_vh;

  localparam int NCH = 4, BW_PS = 16, BW_TS = 24, BW_PROB = 8, FRAC = 8;
  localparam int MAX_ACC = 32, CNT_W = 6;
  localparam int SHIFT = FRAC - BW_PROB + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, en, data_in_en;
  logic [CNT_W-1:0]         cfg_num_acc;
  logic [1:0]               cfg_mode;
  logic [NCH*BW_TS-1:0]     bias_in;
  logic [NCH*BW_PS-1:0]     data_in;
  logic [NCH-1:0]           new_state;
  logic [NCH*BW_PROB-1:0]   new_prob;
  logic                     new_state_en, busy, ovf_flag, drop_err;

  ags_array_vh dut (
    .clk(clk), .rst(rst), .en(en), .cfg_num_acc(cfg_num_acc), .cfg_mode(cfg_mode),
    .bias_in(bias_in), .data_in_en(data_in_en), .data_in(data_in),
    .new_state(new_state), .new_prob(new_prob), .new_state_en(new_state_en),
    .busy(busy), .ovf_flag(ovf_flag), .drop_err(drop_err)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] lfsr_m [NCH];
  bit ovf_m;
  logic [NCH*BW_PS-1:0] beats [$];

  function automatic int eff_n(int n);
    if (n == 0) return 1;
    if (n > MAX_ACC) return MAX_ACC;
    return n;
  endfunction

  function automatic logic [15:0] galois(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] seed_of(int c);
    return (16'hACE1 ^ 16'(c * 32'h1F35)) | 16'h0001;
  endfunction

  function automatic longint sat_m(longint v);
    longint hi, lo;
    hi = (64'sd1 <<< (BW_TS - 1)) - 1;
    lo = -(64'sd1 <<< (BW_TS - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int prob_of(longint s);
    longint p;
    p = (64'sd1 <<< (BW_PROB - 1)) + (s >>> SHIFT);
    if (p < 0) return 0;
    if (p > (1 << BW_PROB) - 1) return (1 << BW_PROB) - 1;
    return int'(p);
  endfunction

  function automatic logic [NCH*BW_PS-1:0] rep_ps(int v);
    logic [NCH*BW_PS-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*BW_PS +: BW_PS] = BW_PS'(v);
    return w;
  endfunction

  function automatic logic [NCH*BW_TS-1:0] rep_ts(int v);
    logic [NCH*BW_TS-1:0] w;
    for (int c = 0; c < NCH; c++) w[c*BW_TS +: BW_TS] = BW_TS'(v);
    return w;
  endfunction

  function automatic logic [NCH*BW_PS-1:0] rand_ps(int lo, int hi);
    logic [NCH*BW_PS-1:0] w;
    for (int c = 0; c < NCH; c++)
      w[c*BW_PS +: BW_PS] = BW_PS'(int'($urandom_range(0, hi - lo)) + lo);
    return w;
  endfunction

  function automatic logic [NCH*BW_TS-1:0] rand_ts(int lo, int hi);
    logic [NCH*BW_TS-1:0] w;
    for (int c = 0; c < NCH; c++)
      w[c*BW_TS +: BW_TS] = BW_TS'(int'($urandom_range(0, hi - lo)) + lo);
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) lfsr_m[c] = seed_of(c);
    ovf_m = 1'b0;
  endtask

  // Expected frame result from the beats queue; advances the model LFSRs.
  task automatic model_frame(input int cfg_n, input int mode, input logic [NCH*BW_TS-1:0] bias,
                             output logic [NCH-1:0] st, output logic [NCH*BW_PROB-1:0] pr);
    int n, p;
    longint s, nxt;
    n = eff_n(cfg_n);
    st = '0;
    pr = '0;
    for (int c = 0; c < NCH; c++) begin
      s = $signed(bias[c*BW_TS +: BW_TS]);
      for (int i = 0; i < n; i++) begin
        nxt = s + longint'($signed(beats[i][c*BW_PS +: BW_PS]));
        s = sat_m(nxt);
        if (s != nxt) ovf_m = 1'b1;
      end
      p = prob_of(s);
      pr[c*BW_PROB +: BW_PROB] = BW_PROB'(p);
      case (mode)
        1:       st[c] = (s >= 0);
        2:       st[c] = 1'b0;
        default: st[c] = (p > int'(lfsr_m[c][BW_PROB-1:0]));
      endcase
    end
    for (int c = 0; c < NCH; c++) lfsr_m[c] = galois(lfsr_m[c]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; data_in_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one frame from the beats queue and captures the result pulse.
  task automatic run_frame(input int cfg_n, input int mode, input logic [NCH*BW_TS-1:0] bias,
                           input int freeze_at, input bit drop_beat,
                           output int lat, output bit one_wide, output logic [NCH-1:0] st,
                           output logic [NCH*BW_PROB-1:0] pr, output bit frz_glitch);
    int n;
    n = eff_n(cfg_n);
    frz_glitch = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == freeze_at) begin
        repeat (5) begin
          @(negedge clk);
          if (new_state_en || busy) frz_glitch = 1'b1;
          en = 1'b0; data_in_en = 1'b1; data_in = {$urandom, $urandom};
        end
      end
      @(negedge clk);
      en = 1'b1; data_in_en = 1'b1; data_in = beats[i];
      if (i == 0) begin
        cfg_num_acc = CNT_W'(cfg_n); cfg_mode = 2'(mode); bias_in = bias;
      end else begin
        cfg_num_acc = CNT_W'($urandom); cfg_mode = 2'($urandom); bias_in = {$urandom, $urandom, $urandom};
      end
    end
    lat = 0; st = '0; pr = '0; one_wide = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      data_in_en = (drop_beat && k == 1);
      if (new_state_en) begin
        lat = k; st = new_state; pr = new_prob;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      one_wide = !new_state_en;
    end
    data_in_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (new_state_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", new_state_en); end
    checks++; if (new_state !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", new_state); end
    checks++; if (new_prob !== '0) begin failures++; $display("FAIL reset_prob got=%h exp=0", new_prob); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_flag); end
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
  endtask

  task automatic test_deterministic();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat; bit w, g;
    beats.delete();
    repeat (4) beats.push_back(rep_ps(64));
    model_frame(4, 1, '0, est, epr);
    run_frame(4, 1, '0, -1, 1'b0, lat, w, st, pr, g);
    checks++; if (lat != 2) begin failures++; $display("FAIL det_latency got=%0d exp=2", lat); end
    checks++; if (w !== 1'b1) begin failures++; $display("FAIL det_pulse_width got_one_wide=%b exp=1", w); end
    checks++; if (st !== 4'hF) begin failures++; $display("FAIL det_state got=%h exp=f", st); end
    checks++; if (pr !== {NCH{8'd192}}) begin failures++; $display("FAIL det_prob got=%h exp=%h", pr, {NCH{8'd192}}); end
    checks++; if (pr !== epr) begin failures++; $display("FAIL det_prob_model got=%h exp=%h", pr, epr); end
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL det_ovf got=%b exp=0", ovf_flag); end
  endtask

  task automatic test_saturation();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat; bit w, g;
    logic [NCH*BW_TS-1:0] b;
    b = rep_ts((1 << 23) - 100);
    beats.delete();
    repeat (2) beats.push_back(rep_ps(200));
    model_frame(2, 1, b, est, epr);
    run_frame(2, 1, b, -1, 1'b0, lat, w, st, pr, g);
    checks++; if (pr !== {NCH{8'hFF}}) begin failures++; $display("FAIL sat_prob got=%h exp=%h", pr, {NCH{8'hFF}}); end
    checks++; if (st !== 4'hF) begin failures++; $display("FAIL sat_state got=%h exp=f", st); end
    checks++; if (ovf_flag !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%b exp=1", ovf_flag); end
    checks++; if (ovf_flag !== ovf_m) begin failures++; $display("FAIL sat_ovf_model got=%b exp=%b", ovf_flag, ovf_m); end
    checks++; if (lat != 2) begin failures++; $display("FAIL sat_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_mode0_stats();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat; bit w, g;
    int ones, mism;
    int bias_v [3] = '{0, -1024, 1024};
    int mode_v [3] = '{0, 0, 3};
    logic [7:0] prob_v [3] = '{8'd128, 8'd0, 8'd255};
    for (int p = 0; p < 3; p++) begin
      ones = 0; mism = 0;
      for (int f = 0; f < 1000; f++) begin
        beats.delete();
        beats.push_back('0);
        model_frame(1, mode_v[p], rep_ts(bias_v[p]), est, epr);
        run_frame(1, mode_v[p], rep_ts(bias_v[p]), -1, 1'b0, lat, w, st, pr, g);
        if (st[0]) ones++;
        if (st !== est || pr !== epr || lat != 2) mism++;
      end
      checks++; if (mism != 0) begin failures++; $display("FAIL stats_model pattern=%0d mismatching_frames=%0d exp=0", p, mism); end
      checks++; if (pr !== {NCH{prob_v[p]}}) begin failures++; $display("FAIL stats_prob pattern=%0d got=%h exp=%h", p, pr, {NCH{prob_v[p]}}); end
      checks++;
      if ((p == 0 && (ones < 450 || ones > 550)) || (p == 1 && ones != 0) || (p == 2 && ones < 990)) begin
        failures++; $display("FAIL stats_ones pattern=%0d got=%0d", p, ones);
      end
    end
  endtask

  task automatic test_en_freeze();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat; bit w, g;
    logic [NCH*BW_TS-1:0] b;
    b = rand_ts(-2000, 2000);
    beats.delete();
    repeat (4) beats.push_back(rand_ps(-500, 500));
    model_frame(4, 1, b, est, epr);
    run_frame(4, 1, b, 2, 1'b0, lat, w, st, pr, g);
    checks++; if (g !== 1'b0) begin failures++; $display("FAIL freeze_glitch got=%b exp=0", g); end
    checks++; if (lat != 2) begin failures++; $display("FAIL freeze_latency got=%0d exp=2", lat); end
    checks++; if (st !== est) begin failures++; $display("FAIL freeze_state got=%h exp=%h", st, est); end
    checks++; if (pr !== epr) begin failures++; $display("FAIL freeze_prob got=%h exp=%h", pr, epr); end
  endtask

  task automatic test_drop();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat; bit w, g;
    logic [NCH*BW_TS-1:0] b;
    checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL drop_pre got=%b exp=0", drop_err); end
    b = rand_ts(-1500, 1500);
    beats.delete();
    repeat (3) beats.push_back(rand_ps(-300, 300));
    model_frame(3, 2, b, est, epr);
    run_frame(3, 2, b, -1, 1'b1, lat, w, st, pr, g);
    checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL drop_flag got=%b exp=1", drop_err); end
    checks++; if (st !== '0) begin failures++; $display("FAIL drop_mode2_state got=%h exp=0", st); end
    checks++; if (pr !== epr) begin failures++; $display("FAIL drop_prob got=%h exp=%h", pr, epr); end
    b = rand_ts(-1500, 1500);
    beats.delete();
    repeat (2) beats.push_back(rand_ps(-300, 300));
    model_frame(2, 1, b, est, epr);
    run_frame(2, 1, b, -1, 1'b0, lat, w, st, pr, g);
    checks++; if (lat != 2) begin failures++; $display("FAIL drop_next_latency got=%0d exp=2", lat); end
    checks++; if (st !== est || pr !== epr) begin failures++; $display("FAIL drop_next_result got=%h/%h exp=%h/%h", st, pr, est, epr); end
  endtask

  task automatic test_reset_mid();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat, pulses; bit w, g;
    logic [NCH*BW_TS-1:0] b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b1; data_in_en = 1'b1; data_in = rand_ps(-300, 300);
      cfg_num_acc = CNT_W'(8); cfg_mode = 2'd1; bias_in = rand_ts(-1000, 1000);
    end
    @(negedge clk);
    rst = 1'b1; data_in_en = 1'b0;
    @(negedge clk);
    checks++; if (new_state !== '0 || new_prob !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h/%h exp=0/0", new_state, new_prob); end
    checks++; if (drop_err !== 1'b0 || ovf_flag !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b exp=00", drop_err, ovf_flag); end
    checks++; if (busy !== 1'b0 || new_state_en !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b%b exp=00", busy, new_state_en); end
    rst = 1'b0;
    model_reset();
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (new_state_en) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_pulse got=%0d exp=0", pulses); end
    b = rand_ts(-800, 800);
    beats.delete();
    repeat (5) beats.push_back(rand_ps(-100, 100));
    model_frame(5, 0, b, est, epr);
    run_frame(5, 0, b, -1, 1'b0, lat, w, st, pr, g);
    checks++; if (lat != 2) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=2", lat); end
    checks++; if (st !== est || pr !== epr) begin failures++; $display("FAIL rstmid_next_result got=%h/%h exp=%h/%h", st, pr, est, epr); end
  endtask

  task automatic test_num_acc_edges();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat; bit w, g;
    logic [NCH*BW_TS-1:0] b;
    b = rand_ts(-600, 600);
    beats.delete();
    beats.push_back(rand_ps(-400, 400));
    model_frame(0, 2, b, est, epr);
    run_frame(0, 2, b, -1, 1'b0, lat, w, st, pr, g);
    checks++; if (lat != 2) begin failures++; $display("FAIL acc0_latency got=%0d exp=2", lat); end
    checks++; if (w !== 1'b1) begin failures++; $display("FAIL acc0_width got_one_wide=%b exp=1", w); end
    checks++; if (st !== '0) begin failures++; $display("FAIL acc0_mode2_state got=%h exp=0", st); end
    checks++; if (pr !== epr) begin failures++; $display("FAIL acc0_prob got=%h exp=%h", pr, epr); end
    b = rand_ts(-600, 600);
    beats.delete();
    repeat (MAX_ACC) beats.push_back(rand_ps(-50, 50));
    model_frame(40, 1, b, est, epr);
    run_frame(40, 1, b, -1, 1'b0, lat, w, st, pr, g);
    checks++; if (lat != 2) begin failures++; $display("FAIL clamp_latency got=%0d exp=2", lat); end
    checks++; if (st !== est || pr !== epr) begin failures++; $display("FAIL clamp_result got=%h/%h exp=%h/%h", st, pr, est, epr); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] st, est; logic [NCH*BW_PROB-1:0] pr, epr; int lat, n, md; bit w, g, wild;
    logic [NCH*BW_TS-1:0] b;
    for (int f = 0; f < 30; f++) begin
      md = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 40));
      wild = ($urandom_range(0, 3) == 0);
      b = wild ? {$urandom, $urandom, $urandom} : rand_ts(-3000, 3000);
      beats.delete();
      for (int i = 0; i < eff_n(n); i++)
        beats.push_back(wild ? {$urandom, $urandom} : rand_ps(-60, 60));
      model_frame(n, md, b, est, epr);
      run_frame(n, md, b, -1, 1'b0, lat, w, st, pr, g);
      checks++; if (lat != 2) begin failures++; $display("FAIL rand_latency frame=%0d got=%0d exp=2", f, lat); end
      checks++; if (st !== est) begin failures++; $display("FAIL rand_state frame=%0d got=%h exp=%h", f, st, est); end
      checks++; if (pr !== epr) begin failures++; $display("FAIL rand_prob frame=%0d got=%h exp=%h", f, pr, epr); end
      checks++; if (ovf_flag !== ovf_m) begin failures++; $display("FAIL rand_ovf frame=%0d got=%b exp=%b", f, ovf_flag, ovf_m); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; data_in_en = 1'b0;
    cfg_num_acc = '0; cfg_mode = '0; bias_in = '0; data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_deterministic();
    test_saturation();
    do_reset();
    test_mode0_stats();
    test_en_freeze();
    test_drop();
    test_reset_mid();
    test_num_acc_edges();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
